// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the RV32I/RV64I immediate
// format of each instruction and hands it downstream through a two-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready
  // (and no flush); the output drains where out_valid && out_ready. in_ready
  // depends only on the skid valid flop, never on out_ready.

  logic [6:0]      opcode;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;

  always_comb begin
    opcode      = in_instr[6:0];
    imm32       = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_fmt     = FMT_ILL;
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          imm32   = {in_instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        end
        7'b0110011: dec_fmt = FMT_NONE;
        // Word-sized ops only exist on RV64.
        7'b0011011: begin
          if (XLEN == 64) begin
            dec_fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          end else begin
            dec_fmt     = FMT_ILL;
            dec_illegal = 1'b1;
          end
        end
        7'b0111011: begin
          if (XLEN == 64) begin
            dec_fmt = FMT_NONE;
          end else begin
            dec_fmt     = FMT_ILL;
            dec_illegal = 1'b1;
          end
        end
        default: begin
          dec_fmt     = FMT_ILL;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    imm_ext        = '0;
    imm_ext[31:0]  = imm32;
    for (int i = 32; i < XLEN; i++) begin
      imm_ext[i] = imm32[31];
    end
  end

  always_comb begin
    dec_entry.instr   = in_instr;
    dec_entry.pc      = in_pc;
    dec_entry.imm     = imm_ext;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, out_free;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // Skid holds the older entry, so it refills the output first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec_entry;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked against an occupancy/queue model and an arithmetic decoder.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_pc32, out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_pc64, out_imm64;
  logic [2:0]  out_fmt64;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_instr(out_instr32), .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64)
  );

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];  // {pc[63:0], instr[31:0]}, oldest first

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decoder: immediates built with signed arithmetic on the instruction word.
  task automatic ref_decode(input logic [31:0] ins, input int xlen,
                            output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    int     si;
    longint s, v;
    si  = ins;
    s   = si;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      fmt = 3'd7; ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin fmt = 3'd1; v = s >>> 20; end
        7'h23: begin fmt = 3'd2; v = (s >>> 25) * 32 + longint'(ins[11:7]); end
        7'h63: begin
          fmt = 3'd3;
          v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2;
        end
        7'h37, 7'h17: begin fmt = 3'd4; v = (s >>> 12) * 4096; end
        7'h6F: begin
          fmt = 3'd5;
          v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
              + longint'(ins[30:21]) * 2;
        end
        7'h33: fmt = 3'd0;
        7'h1B: if (xlen == 64) begin fmt = 3'd1; v = s >>> 20; end else begin fmt = 3'd7; ill = 1'b1; end
        7'h3B: if (xlen == 64) fmt = 3'd0; else begin fmt = 3'd7; ill = 1'b1; end
        default: begin fmt = 3'd7; ill = 1'b1; end
      endcase
    end
    imm = (xlen == 64) ? v : {32'b0, v[31:0]};
  endtask

  task automatic check_outputs();
    int          occ;
    logic [95:0] head;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    occ = exp_q.size();
    chk("out_valid32", {63'b0, out_valid32}, {63'b0, occ > 0});
    chk("in_ready32",  {63'b0, in_ready32},  {63'b0, occ < 2});
    chk("out_valid64", {63'b0, out_valid64}, {63'b0, occ > 0});
    chk("in_ready64",  {63'b0, in_ready64},  {63'b0, occ < 2});
    if (occ > 0) begin
      head = exp_q[0];
      ref_decode(head[31:0], 32, imm, fmt, ill);
      chk("instr32", {32'b0, out_instr32}, {32'b0, head[31:0]});
      chk("pc32",    {32'b0, out_pc32},    {32'b0, head[63:32]});
      chk("imm32",   {32'b0, out_imm32},   imm);
      chk("fmt32",   {61'b0, out_fmt32},   {61'b0, fmt});
      chk("ill32",   {63'b0, out_illegal32}, {63'b0, ill});
      ref_decode(head[31:0], 64, imm, fmt, ill);
      chk("instr64", {32'b0, out_instr64}, {32'b0, head[31:0]});
      chk("pc64",    out_pc64,             head[95:32]);
      chk("imm64",   out_imm64,            imm);
      chk("fmt64",   {61'b0, out_fmt64},   {61'b0, fmt});
      chk("ill64",   {63'b0, out_illegal64}, {63'b0, ill});
    end
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic cycle();
    logic drain, acc;
    @(negedge clk);
    check_outputs();
    drain = (exp_q.size() > 0) && out_ready;
    acc   = in_valid && (exp_q.size() < 2);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (drain) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    logic [31:0] r;
    r        = $urandom();
    in_valid = v;
    in_instr = ins;
    in_pc    = {r, $urandom()};
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[14];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h2B};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 13)]};
  endfunction

  logic [31:0] tv_instr[11] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123452B7,
                                32'h80000297, 32'hFFDFF06F, 32'h00000000, 32'h0000001B,
                                32'h00B50533, 32'h0000003B, 32'hFFF00090};
  logic [31:0] tv_imm32[11] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                                32'h80000000, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [2:0]  tv_fmt32[11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7};
  logic [63:0] tv_imm64[11] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                                64'h0000000012345000, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  logic [2:0]  tv_fmt64[11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd7, 3'd1, 3'd0, 3'd0, 3'd7};

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);

    // Reset state
    #12;
    chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("rst_in_ready32",  {63'b0, in_ready32},  64'd1);
    chk("rst_imm32",       {32'b0, out_imm32},   64'd0);
    chk("rst_instr32",     {32'b0, out_instr32}, 64'd0);
    chk("rst_pc32",        {32'b0, out_pc32},    64'd0);
    chk("rst_fmt32",       {61'b0, out_fmt32},   64'd0);
    chk("rst_ill32",       {63'b0, out_illegal32}, 64'd0);
    chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst_imm64",       out_imm64,            64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode table, streamed at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tv_instr[i]);
      cycle();
      chk($sformatf("tv%0d_imm32", i), {32'b0, out_imm32}, {32'b0, tv_imm32[i]});
      chk($sformatf("tv%0d_fmt32", i), {61'b0, out_fmt32}, {61'b0, tv_fmt32[i]});
      chk($sformatf("tv%0d_ill32", i), {63'b0, out_illegal32}, {63'b0, tv_fmt32[i] == 3'd7});
      chk($sformatf("tv%0d_imm64", i), out_imm64, tv_imm64[i]);
      chk($sformatf("tv%0d_fmt64", i), {61'b0, out_fmt64}, {61'b0, tv_fmt64[i]});
    end
    drive(1'b0, 32'h0);
    cycle();
    cycle();

    // Backpressure: A and B taken, C waits, then all three drain back-to-back
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093); cycle();
    drive(1'b1, 32'h00200113); cycle();
    drive(1'b1, 32'h00300193); cycle();
    chk("bp_in_ready_low", {63'b0, in_ready32}, 64'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 32'h0);
    cycle();
    cycle();
    cycle();

    // Flush with both entries full and a new offer pending
    out_ready = 1'b0;
    drive(1'b1, 32'h00400213); cycle();
    drive(1'b1, 32'h00500293); cycle();
    drive(1'b1, 32'h00600313);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("flush_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("flush_in_ready",  {63'b0, in_ready32},  64'd1);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'h00700393); cycle();
    drive(1'b1, 32'h00800413); cycle();
    drive(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("arst_in_ready32",  {63'b0, in_ready32},  64'd1);
    chk("arst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("arst_in_ready64",  {63'b0, in_ready64},  64'd1);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'hFFF00093);
    cycle();
    drive(1'b0, 32'h0);
    chk("post_rst_valid", {63'b0, out_valid32}, 64'd1);
    chk("post_rst_imm",   {32'b0, out_imm32},   64'h00000000FFFFFFFF);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Randomized traffic with occasional flushes
    for (int n = 0; n < 500; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, rand_instr());
      cycle();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0);
    for (int n = 0; n < 4; n++) cycle();
    chk("final_empty", {63'b0, out_valid32}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It accepts one instruction per cycle over a valid/ready handshake and classifies its format. It produces the sign-extended immediate at XLEN width for all base RV32I/RV64I formats (I, S, B, U, J) and flags illegal opcodes. A two-entry skid buffer gives full throughput with no combinational path from `out_ready` to `in_ready`.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline kill; discards all held entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; registered-derived.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address, passed through.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  instruction passed through.
- `out_pc`  out  XLEN  PC passed through.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_fmt`  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- `out_illegal`  out  1  opcode not supported.

## Operation
- **Opcode decode** (`instr[6:0]`):
  - 0010011, 0000011, 1100111 (JALR), 0001111, 1110011 → I: `instr[31:20]` sign-extended.
  - 0100011 → S: `{instr[31:25], instr[11:7]}` sign-extended.
  - 1100011 → B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}` sign-extended.
  - 0110111, 0010111 → U: `{instr[31:12], 12'b0}` sign-extended to XLEN.
  - 1101111 → J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}` sign-extended.
  - 0110011 → R, imm 0.
  - 0011011 → I and 0111011 → R when XLEN=64; illegal when XLEN=32.
- **Illegal encodings:** any other opcode, or `instr[1:0]` ≠ 2'b11. Result: `out_fmt`=7, `out_illegal`=1, `out_imm`=0. The entry still flows through the handshake normally.
- **Sign extension:** always from the instruction's top immediate bit (`instr[31]`) to the full XLEN.
- **Storage:** output register (`out_*`) plus one skid register, each with its own valid bit. Decode happens before capture.
- **Accept rule:** a transfer is accepted when `in_valid && in_ready`. It lands in the output register if that register is empty or draining this cycle (`out_ready` high); otherwise it lands in the skid.
- **Skid drain:** when the output drains and the skid is full, the skid entry moves to the output register.
- **`in_ready`:** equals `!skid_valid`.
- **Ordering:** strictly FIFO; no entry is dropped or duplicated.
- **Flush:** clears both valid bits at the next edge. An input offered in the flush cycle is discarded, even if `in_ready` was high. Data registers are not cleared.
- **Reset:** `out_valid`=0, skid empty, so `in_ready`=1. `out_imm`, `out_instr`, `out_pc`, `out_fmt` = 0; `out_illegal` = 0.
- **Reset mid-operation:** all held entries are lost immediately (asynchronous).

## Timing
- **Latency:** 1 cycle. An entry accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N.
- **Throughput:** 1 entry/cycle while `out_ready`=1.
- **Output stability:** `out_*` hold stable while `out_valid && !out_ready`.
- **Backpressure:** with `out_ready` low, two entries are accepted; `in_ready` drops after the second.
- **Recovery:** `in_ready` rises the cycle after the skid drains. The output register refills from the skid in the same edge it drains.
- **Simultaneous accept and drain:** with the output full, skid empty and `out_ready`=1, the new entry goes straight to the output register; the skid stays empty.
- **Flush priority:** flush has priority over any accept or drain in the same cycle.
- **No combinational paths:** none from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.

## Test plan
- **Sign-extended I and S (XLEN=32):** `0xFFF00093` (addi -1) → `out_imm`=0xFFFFFFFF, `fmt`=1, one cycle later. `0xFE112E23` (sw -4) → 0xFFFFFFFC, `fmt`=2.
- **B and U formats:** `0xFE000EE3` (beq -4) → `imm`=0xFFFFFFFC, `fmt`=3. `0x123452B7` (lui) → 0x12345000, `fmt`=4. With XLEN=64, `0x80000297` (auipc) → 0xFFFFFFFF80000000.
- **Illegal:** `0x00000000` → `fmt`=7, `illegal`=1, `imm`=0. `0x0000001B` gives `fmt`=7 with XLEN=32, and `fmt`=1, `imm`=0 with XLEN=64.
- **Backpressure:**
  - Hold `out_ready`=0 and offer A, B, C back-to-back: A and B are accepted, `in_ready`=0 while C waits.
  - Raise `out_ready`: outputs A, B, C on consecutive cycles with no bubble.
- **Flush:**
  - Assert `flush` with both entries full and `in_valid`=1: next cycle `out_valid`=0, `in_ready`=1, and the offered entry never appears.
- **Reset:** assert `rst_n`=0 mid-stream, asynchronously, away from a clock edge → `out_valid`=0 and `in_ready`=1 immediately. The first post-reset entry emerges one cycle after acceptance.
